// File: rtl/tlb_lookup_arbiter_if.sv
// Request/response bundle for one TLB lookup client (IF or MEM).
// The requester holds req with a stable addr until gnt; the result returns as a one-cycle pulse.
interface tlb_req_if #(
    parameter int unsigned PFN_W = 3
);
    logic             req;
    logic [31:0]      addr;
    logic             gnt;
    logic             rsp_valid;
    logic [PFN_W-1:0] pfn;
    logic             page_fault;

    modport master (
        output req, addr,
        input  gnt, rsp_valid, pfn, page_fault
    );

    modport slave (
        input  req, addr,
        output gnt, rsp_valid, pfn, page_fault
    );
endinterface

// File: rtl/tlb_lookup_arbiter.sv
// Shares one TLB between instruction fetch and the MEM stage.
// Two-stage pipeline: grant/capture, then compare. MEM has priority with a bounded IF starvation.
module tlb_lookup_arbiter #(
    parameter int unsigned NUM_ENT  = 8,
    parameter int unsigned ENT_W    = 44,
    parameter int unsigned PFN_W    = 3,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_ENT*ENT_W-1:0] TLB,
    input  logic                     flush,
    tlb_req_if.slave                 if_bus,
    tlb_req_if.slave                 mem_bus,
    output logic                     tlb_multi_hit
);

    localparam int unsigned CntW    = $clog2(NUM_ENT + 1);
    localparam logic [3:0]  MaxWait = 4'(MAX_WAIT);

    logic [3:0]       wait_q, wait_d;
    logic             s1_v_q, s1_v_d;
    logic             s1_own_if_q, s1_own_if_d;
    logic [19:0]      s1_vpn_q, s1_vpn_d;

    logic             if_rsp_valid_q, if_rsp_valid_d;
    logic [PFN_W-1:0] if_pfn_q, if_pfn_d;
    logic             if_fault_q, if_fault_d;
    logic             mem_rsp_valid_q, mem_rsp_valid_d;
    logic [PFN_W-1:0] mem_pfn_q, mem_pfn_d;
    logic             mem_fault_q, mem_fault_d;
    logic             multi_q, multi_d;

    logic             if_gnt, mem_gnt;
    logic [CntW-1:0]  hit_cnt;
    logic [PFN_W-1:0] hit_pfn;
    logic             s1_live;
    logic             one_hit, no_hit, many_hit;

    // Arbitration and starvation counter.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (wait_q == MaxWait && if_bus.req && !flush) begin
            if_gnt = 1'b1;
        end else begin
            mem_gnt = mem_bus.req;
            if_gnt  = if_bus.req & ~mem_bus.req & ~flush;
        end

        wait_d = wait_q;
        if (!if_bus.req || flush || if_gnt) begin
            wait_d = '0;
        end else if (wait_q != MaxWait) begin
            wait_d = wait_q + 4'd1;
        end

        s1_v_d      = if_gnt | mem_gnt;
        s1_own_if_d = if_gnt;
        s1_vpn_d    = if_gnt ? if_bus.addr[31:12] : mem_bus.addr[31:12];
    end

    assign if_bus.gnt  = if_gnt;
    assign mem_bus.gnt = mem_gnt;

    // Compare stage; the TLB image is sampled here, one cycle after the grant.
    always_comb begin
        hit_cnt = '0;
        hit_pfn = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            if (TLB[ENT_W*i+24 +: 20] == s1_vpn_q && TLB[ENT_W*i+3] && TLB[ENT_W*i+2]) begin
                hit_cnt = hit_cnt + CntW'(1);
                hit_pfn = TLB[ENT_W*i+4 +: PFN_W];
            end
        end
        one_hit  = (hit_cnt == CntW'(1));
        no_hit   = (hit_cnt == '0);
        many_hit = !one_hit && !no_hit;

        // A flush kills an IF lookup sitting between the two stages.
        s1_live = s1_v_q & ~(flush & s1_own_if_q);

        if_rsp_valid_d  = s1_live & s1_own_if_q;
        if_pfn_d        = (if_rsp_valid_d && one_hit) ? hit_pfn : '0;
        if_fault_d      = if_rsp_valid_d & no_hit;
        mem_rsp_valid_d = s1_live & ~s1_own_if_q;
        mem_pfn_d       = (mem_rsp_valid_d && one_hit) ? hit_pfn : '0;
        mem_fault_d     = mem_rsp_valid_d & no_hit;
        multi_d         = s1_live & many_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q          <= '0;
            s1_v_q          <= 1'b0;
            s1_own_if_q     <= 1'b0;
            s1_vpn_q        <= '0;
            if_rsp_valid_q  <= 1'b0;
            if_pfn_q        <= '0;
            if_fault_q      <= 1'b0;
            mem_rsp_valid_q <= 1'b0;
            mem_pfn_q       <= '0;
            mem_fault_q     <= 1'b0;
            multi_q         <= 1'b0;
        end else begin
            wait_q          <= wait_d;
            s1_v_q          <= s1_v_d;
            s1_own_if_q     <= s1_own_if_d;
            s1_vpn_q        <= s1_vpn_d;
            if_rsp_valid_q  <= if_rsp_valid_d;
            if_pfn_q        <= if_pfn_d;
            if_fault_q      <= if_fault_d;
            mem_rsp_valid_q <= mem_rsp_valid_d;
            mem_pfn_q       <= mem_pfn_d;
            mem_fault_q     <= mem_fault_d;
            multi_q         <= multi_d;
        end
    end

    assign if_bus.rsp_valid   = if_rsp_valid_q;
    assign if_bus.pfn         = if_pfn_q;
    assign if_bus.page_fault  = if_fault_q;
    assign mem_bus.rsp_valid  = mem_rsp_valid_q;
    assign mem_bus.pfn        = mem_pfn_q;
    assign mem_bus.page_fault = mem_fault_q;
    assign tlb_multi_hit      = multi_q;

    // Page offset and reserved entry bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{TLB, if_bus.addr[11:0], mem_bus.addr[11:0]};

endmodule

// File: tb/tb_tlb_lookup_arbiter.sv
// Directed bench for tlb_lookup_arbiter: grant model plus a scoreboard of expected responses
// keyed by the cycle they must appear in.
module tb_tlb_lookup_arbiter;

    localparam int unsigned NUM_ENT  = 8;
    localparam int unsigned ENT_W    = 44;
    localparam int unsigned PFN_W    = 3;
    localparam int unsigned MAX_WAIT = 4;

    typedef struct {
        int         cyc;
        bit         own_if;
        logic [2:0] pfn;
        bit         fault;
        bit         multi;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     flush = 1'b0;
    logic [NUM_ENT*ENT_W-1:0] tlb_img = '0;
    logic                     multi_hit;

    tlb_req_if #(.PFN_W(PFN_W)) if_bus ();
    tlb_req_if #(.PFN_W(PFN_W)) mem_bus ();

    tlb_lookup_arbiter #(
        .NUM_ENT (NUM_ENT),
        .ENT_W   (ENT_W),
        .PFN_W   (PFN_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .TLB          (tlb_img),
        .flush        (flush),
        .if_bus       (if_bus),
        .mem_bus      (mem_bus),
        .tlb_multi_hit(multi_hit)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wait_m = 0;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_entry(input int i, input logic [19:0] vpn, input logic [2:0] pfn,
                             input bit v, input bit p);
        logic [43:0] e;
        e = '0;
        e[43:24] = vpn;
        e[6:4]   = pfn;
        e[3]     = v;
        e[2]     = p;
        tlb_img[ENT_W*i +: ENT_W] = e;
    endtask

    task automatic model_lookup(input logic [19:0] vpn, output logic [2:0] pfn,
                                output bit fault, output bit multi);
        int          n;
        logic [2:0]  p;
        logic [43:0] e;
        n = 0;
        p = '0;
        for (int i = 0; i < NUM_ENT; i++) begin
            e = tlb_img[ENT_W*i +: ENT_W];
            if (e[43:24] == vpn && e[3] && e[2]) begin
                n++;
                p = e[6:4];
            end
        end
        fault = (n == 0);
        multi = (n > 1);
        pfn   = (n == 1) ? p : 3'd0;
    endtask

    task automatic check_rsp();
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '{cyc: 0, own_if: 1'b0, pfn: 3'd0, fault: 1'b0, multi: 1'b0};
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("sb_late", sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e    = sb.pop_front();
            have = 1'b1;
        end
        chk("if_rsp_valid", if_bus.rsp_valid, have && e.own_if);
        chk("if_pfn", if_bus.pfn, (have && e.own_if) ? e.pfn : 3'd0);
        chk("if_fault", if_bus.page_fault, have && e.own_if && e.fault);
        chk("mem_rsp_valid", mem_bus.rsp_valid, have && !e.own_if);
        chk("mem_pfn", mem_bus.pfn, (have && !e.own_if) ? e.pfn : 3'd0);
        chk("mem_fault", mem_bus.page_fault, have && !e.own_if && e.fault);
        chk("multi_hit", multi_hit, have && e.multi);
    endtask

    // One clock cycle: check outputs, drive, check grants, record expected results.
    task automatic cycle(input bit ir, input logic [31:0] ia, input bit mr,
                         input logic [31:0] ma, input bit fl);
        bit         eig, emg, f, m;
        logic [2:0] p;
        check_rsp();
        if_bus.req   = ir;
        if_bus.addr  = ia;
        mem_bus.req  = mr;
        mem_bus.addr = ma;
        flush        = fl;
        #1;
        if (wait_m == MAX_WAIT && ir && !fl) begin
            eig = 1'b1;
            emg = 1'b0;
        end else begin
            emg = mr;
            eig = ir && !mr && !fl;
        end
        chk("if_gnt", if_bus.gnt, eig);
        chk("mem_gnt", mem_bus.gnt, emg);
        if (fl) begin
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].own_if && sb[k].cyc == cyc + 1) sb.delete(k);
            end
        end
        if (eig || emg) begin
            model_lookup(eig ? ia[31:12] : ma[31:12], p, f, m);
            sb.push_back('{cyc: cyc + 2, own_if: eig, pfn: p, fault: f, multi: m});
        end
        if (!ir || fl || eig) wait_m = 0;
        else if (wait_m < MAX_WAIT) wait_m++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_rsp"}, if_bus.rsp_valid, 1'b0);
        chk({tag, "_if_pfn"}, if_bus.pfn, 3'd0);
        chk({tag, "_if_fault"}, if_bus.page_fault, 1'b0);
        chk({tag, "_mem_rsp"}, mem_bus.rsp_valid, 1'b0);
        chk({tag, "_mem_pfn"}, mem_bus.pfn, 3'd0);
        chk({tag, "_mem_fault"}, mem_bus.page_fault, 1'b0);
        chk({tag, "_multi"}, multi_hit, 1'b0);
    endtask

    initial begin
        if_bus.req   = 1'b0;
        if_bus.addr  = '0;
        mem_bus.req  = 1'b0;
        mem_bus.addr = '0;
        set_entry(1, 20'h00001, 3'd2, 1'b1, 1'b1);
        set_entry(2, 20'h12345, 3'd6, 1'b1, 1'b0);
        set_entry(3, 20'h00400, 3'd5, 1'b1, 1'b1);
        set_entry(4, 20'h00777, 3'd7, 1'b1, 1'b1);
        set_entry(5, 20'h00050, 3'd1, 1'b1, 1'b1);
        set_entry(6, 20'h00001, 3'd4, 1'b1, 1'b1);
        set_entry(7, 20'h00400, 3'd3, 1'b0, 1'b1);

        #2;
        chk_all_zero("reset");
        chk("reset_if_gnt", if_bus.gnt, 1'b0);
        chk("reset_mem_gnt", mem_bus.gnt, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single IF hit.
        cycle(1'b1, 32'h00400ABC, 1'b0, 32'h0, 1'b0);
        idle(3);

        // Both held: MEM wins until IF has waited MAX_WAIT cycles.
        for (int k = 0; k < 7; k++) cycle(1'b1, 32'h00777000, 1'b1, 32'h00050123, 1'b0);
        idle(3);

        // MEM miss, then a match that is not present.
        cycle(1'b0, 32'h0, 1'b1, 32'h0ABCD000, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h12345000, 1'b0);
        idle(3);

        // Flush kills the IF lookup in flight; MEM granted during the flush still answers.
        cycle(1'b1, 32'h00400000, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00777000, 1'b1);
        cycle(1'b1, 32'h00050000, 1'b0, 32'h0, 1'b1);
        idle(3);

        // Multi-hit on both owners.
        cycle(1'b1, 32'h00001FFF, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00001000, 1'b0);
        idle(3);

        // Alternating owners, back-to-back.
        cycle(1'b1, 32'h00400000, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00777000, 1'b0);
        cycle(1'b1, 32'h00050000, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h0ABCD000, 1'b0);
        idle(3);

        // Reset mid-stream drops in-flight results immediately.
        cycle(1'b1, 32'h00400000, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 32'h00777000, 1'b0);
        if_bus.req  = 1'b0;
        mem_bus.req = 1'b0;
        rst_n       = 1'b0;
        #1;
        chk_all_zero("midrst");
        sb.delete();
        wait_m = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc += 2;
        idle(3);
        cycle(1'b0, 32'h0, 1'b1, 32'h00050000, 1'b0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
